// File: rtl/sobel_edge_filter.sv
// Purpose : 3x3 Sobel edge filter on RGB444 neighbourhoods, driving RGB444 video in one of four display modes.
// Latency : fixed 4 CLK25 cycles from pixel/sync inputs to rgb_out and the sync outputs, in every mode.
// Backpr. : none; accepts one pixel per cycle, never stalls, has no ready signal.
//
// Ports:
//   CLK25, reset           pixel clock; synchronous active-high reset
//   pix_C..pix_NW          3x3 neighbourhood, RGB444 {R,G,B}, aligned with active_in
//   active_in/hsync_in/vsync_in  pixel valid and active-low syncs
//   mode_in, thresh_in     requested mode / edge threshold, latched on vsync_in falling edge
//   rgb_out                RGB444 video (black outside the active area)
//   active_out/hsync_out/vsync_out  inputs delayed by 4 cycles
//   mode_cur               mode currently in effect
module sobel_edge_filter #(
  parameter logic [7:0] THRESH_DEFAULT = 8'd64,
  parameter logic [1:0] MODE_DEFAULT   = 2'd3
) (
  input  logic        CLK25,
  input  logic        reset,
  input  logic [11:0] pix_C,
  input  logic [11:0] pix_N,
  input  logic [11:0] pix_NE,
  input  logic [11:0] pix_E,
  input  logic [11:0] pix_SE,
  input  logic [11:0] pix_S,
  input  logic [11:0] pix_SW,
  input  logic [11:0] pix_W,
  input  logic [11:0] pix_NW,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  mode_in,
  input  logic [7:0]  thresh_in,
  output logic [11:0] rgb_out,
  output logic        active_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [1:0]  mode_cur
);

  // Grayscale weights sum to 16, so the result tops out at 240 and fits 8 bits.
  function automatic logic [7:0] gray8(input logic [11:0] p);
    return (8'd5 * {4'b0000, p[11:8]}) +
           (8'd9 * {4'b0000, p[7:4]})  +
           (8'd2 * {4'b0000, p[3:0]});
  endfunction

  // ---------------------------------------------------------------------------
  // Frame-synchronous parameter latch. Changes only at the vsync falling edge,
  // when no active pixel can be in flight, so stage 4 may use mode_cur directly.
  // ---------------------------------------------------------------------------
  logic       vsync_prev;
  logic [7:0] thresh_cur;

  always_ff @(posedge CLK25) begin
    if (reset) begin
      vsync_prev <= 1'b1;
      mode_cur   <= MODE_DEFAULT;
      thresh_cur <= THRESH_DEFAULT;
    end else begin
      vsync_prev <= vsync_in;
      if (!vsync_in && vsync_prev) begin
        mode_cur   <= mode_in;
        thresh_cur <= thresh_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Validity / sync delay lines; bit 3 is the output, bit 2 lines up with stage 3.
  // ---------------------------------------------------------------------------
  logic [3:0] act_sr, hs_sr, vs_sr;

  always_ff @(posedge CLK25) begin
    if (reset) begin
      act_sr <= 4'h0;
      hs_sr  <= 4'hF;
      vs_sr  <= 4'hF;
    end else begin
      act_sr <= {act_sr[2:0], active_in};
      hs_sr  <= {hs_sr[2:0], hsync_in};
      vs_sr  <= {vs_sr[2:0], vsync_in};
    end
  end

  assign active_out = act_sr[3];
  assign hsync_out  = hs_sr[3];
  assign vsync_out  = vs_sr[3];

  // ---------------------------------------------------------------------------
  // Stage 1: grayscale. Neighbours indexed 1..8 = N, NE, E, SE, S, SW, W, NW.
  // The centre only ever feeds the gray display, so only its top nibble is kept.
  // ---------------------------------------------------------------------------
  logic [11:0] nb [1:8];
  logic [7:0]  nb_gray_s1 [1:8];
  logic [3:0]  gray_c_s1;
  logic [11:0] pix_c_s1;

  always_comb begin
    nb[1] = pix_N;
    nb[2] = pix_NE;
    nb[3] = pix_E;
    nb[4] = pix_SE;
    nb[5] = pix_S;
    nb[6] = pix_SW;
    nb[7] = pix_W;
    nb[8] = pix_NW;
  end

  always_ff @(posedge CLK25) begin
    if (reset) begin
      for (int k = 1; k <= 8; k++) nb_gray_s1[k] <= 8'h00;
      gray_c_s1 <= 4'h0;
      pix_c_s1  <= 12'h000;
    end else begin
      for (int k = 1; k <= 8; k++) nb_gray_s1[k] <= gray8(nb[k]);
      gray_c_s1 <= 4'(gray8(pix_C) >> 4);
      pix_c_s1  <= pix_C;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: signed gradients, +/-960 worst case fits 11 bits.
  // ---------------------------------------------------------------------------
  logic signed [10:0] gs [1:8];
  logic signed [10:0] gx_nx, gy_nx, gx_s2, gy_s2;
  logic [3:0]         gray_c_s2;
  logic [11:0]        pix_c_s2;

  always_comb begin
    for (int k = 1; k <= 8; k++) gs[k] = $signed({3'b000, nb_gray_s1[k]});
    gx_nx = (gs[2] + (gs[3] <<< 1) + gs[4]) - (gs[8] + (gs[7] <<< 1) + gs[6]);
    gy_nx = (gs[6] + (gs[5] <<< 1) + gs[4]) - (gs[8] + (gs[1] <<< 1) + gs[2]);
  end

  always_ff @(posedge CLK25) begin
    if (reset) begin
      gx_s2     <= '0;
      gy_s2     <= '0;
      gray_c_s2 <= 4'h0;
      pix_c_s2  <= 12'h000;
    end else begin
      gx_s2     <= gx_nx;
      gy_s2     <= gy_nx;
      gray_c_s2 <= gray_c_s1;
      pix_c_s2  <= pix_c_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: L1 magnitude, scaled by 1/4 and saturated to 8 bits, then threshold.
  // ---------------------------------------------------------------------------
  logic [10:0] abs_x, abs_y, sum_nx, quarter;
  logic [7:0]  mag_nx;
  logic        edge_nx;
  logic [3:0]  mag_s3, gray_c_s3;
  logic        edge_s3;
  logic [11:0] pix_c_s3;

  always_comb begin
    abs_x   = gx_s2[10] ? 11'(-gx_s2) : 11'(gx_s2);
    abs_y   = gy_s2[10] ? 11'(-gy_s2) : 11'(gy_s2);
    sum_nx  = abs_x + abs_y;
    quarter = sum_nx >> 2;
    mag_nx  = (quarter > 11'd255) ? 8'hFF : quarter[7:0];
    edge_nx = (mag_nx >= thresh_cur);
  end

  always_ff @(posedge CLK25) begin
    if (reset) begin
      mag_s3    <= 4'h0;
      edge_s3   <= 1'b0;
      gray_c_s3 <= 4'h0;
      pix_c_s3  <= 12'h000;
    end else begin
      mag_s3    <= mag_nx[7:4];
      edge_s3   <= edge_nx;
      gray_c_s3 <= gray_c_s2;
      pix_c_s3  <= pix_c_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: display mux, blanked outside the active area.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK25) begin
    if (reset) begin
      rgb_out <= 12'h000;
    end else if (!act_sr[2]) begin
      rgb_out <= 12'h000;
    end else begin
      case (mode_cur)
        2'd0:    rgb_out <= pix_c_s3;
        2'd1:    rgb_out <= {gray_c_s3, gray_c_s3, gray_c_s3};
        2'd2:    rgb_out <= {mag_s3, mag_s3, mag_s3};
        default: rgb_out <= edge_s3 ? 12'hFFF : 12'h000;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Purpose : self-checking bench for sobel_edge_filter against a behavioural model.
// Latency : model delays expected outputs by 4 clocks.
// Backpr. : none; one stimulus vector per clock.
module tb_sobel_edge_filter;

  localparam logic [7:0] THR_DEF  = 8'd64;
  localparam logic [1:0] MODE_DEF = 2'd3;

  logic        CLK25 = 1'b0;
  logic        reset;
  logic [11:0] px [9];  // 0 C, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW
  logic        active_in, hsync_in, vsync_in;
  logic [1:0]  mode_in;
  logic [7:0]  thresh_in;
  logic [11:0] rgb_out;
  logic        active_out, hsync_out, vsync_out;
  logic [1:0]  mode_cur;

  always #20 CLK25 = ~CLK25;

  sobel_edge_filter #(.THRESH_DEFAULT(THR_DEF), .MODE_DEFAULT(MODE_DEF)) dut (
    .CLK25(CLK25), .reset(reset),
    .pix_C(px[0]), .pix_N(px[1]), .pix_NE(px[2]), .pix_E(px[3]), .pix_SE(px[4]),
    .pix_S(px[5]), .pix_SW(px[6]), .pix_W(px[7]), .pix_NW(px[8]),
    .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mode_in(mode_in), .thresh_in(thresh_in),
    .rgb_out(rgb_out), .active_out(active_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .mode_cur(mode_cur)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        act;
    logic        hs;
    logic        vs;
  } out_t;

  out_t        pipe[$];
  int          checks = 0;
  int          fails  = 0;
  logic [1:0]  m_mode;
  logic [7:0]  m_thr;
  logic        m_vprev;

  function automatic int gray(input logic [11:0] p);
    int r, g, b;
    r = p[11:8]; g = p[7:4]; b = p[3:0];
    return 5 * r + 9 * g + 2 * b;
  endfunction

  function automatic int sobel_mag(input logic [11:0] q [9]);
    int gx, gy, s;
    gx = (gray(q[2]) + 2 * gray(q[3]) + gray(q[4])) - (gray(q[8]) + 2 * gray(q[7]) + gray(q[6]));
    gy = (gray(q[6]) + 2 * gray(q[5]) + gray(q[4])) - (gray(q[8]) + 2 * gray(q[1]) + gray(q[2]));
    s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    s  = s / 4;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic logic [11:0] model_rgb(input logic [11:0] q [9], input logic act,
                                            input logic [1:0] mode, input logic [7:0] thr);
    int v;
    if (!act) return 12'h000;
    case (mode)
      2'd0: return q[0];
      2'd1: begin v = gray(q[0]) / 16; return 12'(v * 12'h111); end
      2'd2: begin v = sobel_mag(q) / 16; return 12'(v * 12'h111); end
      default: return (sobel_mag(q) >= int'(thr)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: update the model with the current inputs, clock, then compare.
  task automatic step();
    out_t e;
    if (reset) begin
      pipe.delete();
      e = '{rgb: 12'h000, act: 1'b0, hs: 1'b1, vs: 1'b1};
      repeat (3) pipe.push_back(e);
      m_mode  = MODE_DEF;
      m_thr   = THR_DEF;
      m_vprev = 1'b1;
    end else begin
      if (!vsync_in && m_vprev) begin
        m_mode = mode_in;
        m_thr  = thresh_in;
      end
      m_vprev = vsync_in;
      e.rgb = model_rgb(px, active_in, m_mode, m_thr);
      e.act = active_in;
      e.hs  = hsync_in;
      e.vs  = vsync_in;
      pipe.push_back(e);
      e = pipe.pop_front();
    end
    @(posedge CLK25);
    #1;
    check("rgb_out", rgb_out, e.rgb);
    check("active_out", 12'(active_out), 12'(e.act));
    check("hsync_out", 12'(hsync_out), 12'(e.hs));
    check("vsync_out", 12'(vsync_out), 12'(e.vs));
    check("mode_cur", 12'(mode_cur), 12'(m_mode));
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic rand_pix();
    for (int i = 0; i < 9; i++) px[i] = 12'($urandom);
  endtask

  task automatic fill_pix(input logic [11:0] v);
    for (int i = 0; i < 9; i++) px[i] = v;
  endtask

  // Blank long enough to drain active pixels, then pulse vsync to latch mode/thresh.
  task automatic new_frame(input logic [1:0] m, input logic [7:0] t);
    active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    hold(5);
    mode_in = m; thresh_in = t; vsync_in = 1'b0;
    hold(2);
    vsync_in = 1'b1;
    hold(1);
    mode_in = 2'($urandom); thresh_in = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; fill_pix(12'h000);
    active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    mode_in = 2'd0; thresh_in = 8'd0;
    hold(2);
    check("reset_rgb", rgb_out, 12'h000);
    check("reset_mode", 12'(mode_cur), 12'(MODE_DEF));
    reset = 1'b0;

    // Passthrough with toggling hsync.
    new_frame(2'd0, 8'd64);
    rand_pix(); px[0] = 12'hA5C; active_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hsync_in = 1'($urandom);
      step();
      if (i == 3) check("mode0_pass", rgb_out, 12'hA5C);
    end

    // Gray, then blanked.
    new_frame(2'd1, 8'd64);
    fill_pix(12'hF00); active_in = 1'b1;
    hold(4);
    check("mode1_gray", rgb_out, 12'h444);
    active_in = 1'b0;
    hold(4);
    check("mode1_blank", rgb_out, 12'h000);

    // Magnitude: vertical step edge, then flat field.
    new_frame(2'd2, 8'd64);
    fill_pix(12'h000); px[2] = 12'hFFF; px[3] = 12'hFFF; px[4] = 12'hFFF;
    active_in = 1'b1;
    hold(4);
    check("mode2_edge", rgb_out, 12'hFFF);
    fill_pix(12'h777);
    hold(4);
    check("mode2_flat", rgb_out, 12'h000);

    // Saturated magnitude against the highest threshold.
    new_frame(2'd3, 8'd255);
    fill_pix(12'h000);
    px[2] = 12'hFFF; px[3] = 12'hFFF; px[4] = 12'hFFF; px[5] = 12'hFFF; px[6] = 12'hFFF;
    active_in = 1'b1;
    hold(4);
    check("sat_255", rgb_out, 12'hFFF);

    // Threshold boundary at mag8 = 67.
    new_frame(2'd3, 8'd67);
    fill_pix(12'h000); px[3] = 12'h0F0; active_in = 1'b1;
    hold(4);
    check("thr_67", rgb_out, 12'hFFF);
    new_frame(2'd3, 8'd68);
    fill_pix(12'h000); px[3] = 12'h0F0; active_in = 1'b1;
    hold(4);
    check("thr_68", rgb_out, 12'h000);

    // Mid-frame mode request is ignored until the next vsync falling edge.
    new_frame(2'd3, 8'd64);
    mode_in = 2'd0; active_in = 1'b1;
    for (int i = 0; i < 8; i++) begin rand_pix(); step(); end
    check("midframe_hold", 12'(mode_cur), 12'd3);
    active_in = 1'b0;
    hold(5);
    vsync_in = 1'b0;
    hold(1);
    check("vsync_latch", 12'(mode_cur), 12'd0);
    vsync_in = 1'b1;
    hold(1);

    // Reset mid-line, coincident with a vsync falling edge.
    active_in = 1'b1; hsync_in = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_pix(); px[0] = 12'h5A5; step(); end
    reset = 1'b1; vsync_in = 1'b0; mode_in = 2'd0;
    hold(1);
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_hsync", 12'(hsync_out), 12'd1);
    check("rst_vsync", 12'(vsync_out), 12'd1);
    check("rst_mode", 12'(mode_cur), 12'd3);
    reset = 1'b0; vsync_in = 1'b1; hsync_in = 1'b1;
    for (int i = 0; i < 6; i++) begin rand_pix(); step(); end

    // Falling edge on the first cycle after reset is honoured.
    active_in = 1'b0;
    hold(5);
    reset = 1'b1;
    hold(1);
    reset = 1'b0; vsync_in = 1'b0; mode_in = 2'd2; thresh_in = 8'd100;
    hold(1);
    check("post_rst_latch", 12'(mode_cur), 12'd2);
    vsync_in = 1'b1;
    hold(2);

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      new_frame(2'($urandom), 8'($urandom));
      for (int l = 0; l < 4; l++) begin
        active_in = 1'b1; hsync_in = 1'b1;
        for (int p = 0; p < 24; p++) begin rand_pix(); step(); end
        active_in = 1'b0;
        hold(2);
        hsync_in = 1'b0;
        hold(3);
        hsync_in = 1'b1;
        hold(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
